// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared widths, FIFO sizing, polarity codes and the packed
//               event word layout for the pixel-array arbiter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package arbiter_pkg;

    localparam int SIZE       = 32;  // timestamp width
    localparam int ROW_ADD    = 3;
    localparam int COL_ADD    = 3;
    localparam int POLARITY   = 2;
    localparam int WIDTH      = SIZE + ROW_ADD + COL_ADD + 1;

    localparam int FIFO_DEPTH = 16;
    localparam int DROP_W     = 16;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [POLARITY-1:0] POL_ON  = 2'b10;
    localparam logic [POLARITY-1:0] POL_OFF = 2'b01;

    // Event word, MSB first: timestamp, row, column, ON/OFF flag.
    typedef struct packed {
        logic [SIZE-1:0]    ts;
        logic [ROW_ADD-1:0] row;
        logic [COL_ADD-1:0] col;
        logic               pol;
    } event_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. Pointers carry an
//               extra wrap bit so full and empty are distinguished without
//               a separate occupancy register.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_ptr_one = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    // Head entry falls straight through to the output.
    assign o_rd_data = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    // Storage has no reset: stale contents are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_push_data;
        end
    end

    // Pointer advance; push and pop may happen in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/event_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : event_packet_fifo
// Description : Timestamps granted pixel events, packs them into event words
//               and buffers them in a FWFT FIFO drained over valid/ready.
//               Invalid polarities and events offered while full are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module event_packet_fifo
    import arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = arbiter_pkg::FIFO_DEPTH,
    parameter int DROP_W     = arbiter_pkg::DROP_W
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          ts_clear_i,
    input  logic                          evt_valid_i,
    output logic                          evt_ready_o,
    input  logic [ROW_ADD-1:0]            row_add_i,
    input  logic [COL_ADD-1:0]            col_add_i,
    input  logic [POLARITY-1:0]           polarity_i,
    output logic                          pkt_valid_o,
    input  logic                          pkt_ready_i,
    output logic [WIDTH-1:0]              pkt_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DROP_W-1:0]             drop_cnt_o
);

    if ($bits(event_t) != WIDTH) begin : g_event_width_check
        $error("event_t width does not match WIDTH");
    end

    logic [SIZE-1:0]   r_ts;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              w_pol_ok;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    event_t            w_evt;

    // Ready depends only on registered occupancy, never on the consumer.
    assign evt_ready_o = ~full_o;
    assign w_accept    = evt_valid_i & evt_ready_o;
    assign w_pol_ok    = (polarity_i == POL_ON) || (polarity_i == POL_OFF);
    assign w_push      = w_accept & w_pol_ok;
    // Lost events: bad polarity on an accepted handshake, or any offer while full.
    assign w_drop      = evt_valid_i & (full_o | ~w_pol_ok);

    assign pkt_valid_o = ~empty_o;
    assign w_pop       = pkt_valid_o & pkt_ready_i;
    assign drop_cnt_o  = r_drop_cnt;

    assign w_evt.ts  = r_ts;
    assign w_evt.row = row_add_i;
    assign w_evt.col = col_add_i;
    assign w_evt.pol = polarity_i[1];

    // Free-running timestamp; clear has priority over increment.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ts <= '0;
        end else if (ts_clear_i) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + SIZE'(1);
        end
    end

    // Saturating count of discarded events.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk_i),
        .i_rst_n     (reset_i),
        .i_push      (w_push),
        .i_push_data (w_evt),
        .i_pop       (w_pop),
        .o_rd_data   (pkt_data_o),
        .o_count     (fifo_count_o),
        .o_full      (full_o),
        .o_empty     (empty_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_event_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_packet_fifo
// Description : Self-checking bench for event_packet_fifo against a queue-based
//               reference model of the event buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_packet_fifo;
    import arbiter_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk_i       = 1'b0;
    logic              reset_i     = 1'b0;
    logic              ts_clear_i  = 1'b0;
    logic              evt_valid_i = 1'b0;
    logic              pkt_ready_i = 1'b0;
    logic [2:0]        row_add_i   = '0;
    logic [2:0]        col_add_i   = '0;
    logic [1:0]        polarity_i  = '0;
    logic              evt_ready_o;
    logic              pkt_valid_o;
    logic              full_o;
    logic              empty_o;
    logic [WIDTH-1:0]  pkt_data_o;
    logic [CW-1:0]     fifo_count_o;
    logic [15:0]       drop_cnt_o;

    // Reference model state
    logic [WIDTH-1:0]  mq[$];
    logic [31:0]       m_ts;
    logic [15:0]       m_drop;

    int n_cmp = 0;
    int n_err = 0;

    event_packet_fifo #(.FIFO_DEPTH(DEPTH), .DROP_W(16)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ts_clear_i   (ts_clear_i),
        .evt_valid_i  (evt_valid_i),
        .evt_ready_o  (evt_ready_o),
        .row_add_i    (row_add_i),
        .col_add_i    (col_add_i),
        .polarity_i   (polarity_i),
        .pkt_valid_o  (pkt_valid_o),
        .pkt_ready_i  (pkt_ready_i),
        .pkt_data_o   (pkt_data_o),
        .fifo_count_o (fifo_count_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached (observed running, expected finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".evt_ready"}, 64'(evt_ready_o), 64'(mq.size() != DEPTH));
        chk({where, ".pkt_valid"}, 64'(pkt_valid_o), 64'(mq.size() != 0));
        chk({where, ".full"},      64'(full_o),      64'(mq.size() == DEPTH));
        chk({where, ".empty"},     64'(empty_o),     64'(mq.size() == 0));
        chk({where, ".count"},     64'(fifo_count_o), 64'(mq.size()));
        chk({where, ".drop"},      64'(drop_cnt_o),  64'(m_drop));
        if (mq.size() != 0) chk({where, ".data"}, 64'(pkt_data_o), 64'(mq[0]));
    endtask

    // One clock: drive at negedge, advance model at posedge, check at negedge.
    task automatic cycle(input string where, input logic v, input logic [2:0] r,
                         input logic [2:0] c, input logic [1:0] p,
                         input logic rdy, input logic clr);
        logic full_now;
        logic pol_ok;
        evt_valid_i = v; row_add_i = r; col_add_i = c; polarity_i = p;
        pkt_ready_i = rdy; ts_clear_i = clr;
        @(posedge clk_i);
        full_now = (mq.size() == DEPTH);
        pol_ok   = (p == 2'b10) || (p == 2'b01);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (v && !full_now && pol_ok) mq.push_back({m_ts, r, c, p[1]});
        if (v && (full_now || !pol_ok) && m_drop != 16'hFFFF) m_drop++;
        m_ts = clr ? 32'd0 : m_ts + 32'd1;
        @(negedge clk_i);
        evt_valid_i = 1'b0; pkt_ready_i = 1'b0; ts_clear_i = 1'b0;
        check_all(where);
    endtask

    function automatic logic [1:0] rand_pol();
        return ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    endfunction

    initial begin
        logic [31:0] base_ts;
        mq.delete(); m_ts = '0; m_drop = '0;

        // Reset state
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_all("reset");
        reset_i = 1'b1;

        // Single ON event after 5 idle cycles
        repeat (5) cycle("idle", 0, 0, 0, 0, 0, 0);
        cycle("single", 1, 3'd3, 3'd5, 2'b10, 0, 0);
        chk("single_word", 64'(pkt_data_o), 64'({32'd5, 3'd3, 3'd5, 1'b1}));
        chk("single_count", 64'(fifo_count_o), 64'd1);
        repeat (2) cycle("drain0", 0, 0, 0, 0, 1, 0);

        // Streaming push/pop
        for (int i = 0; i < 100; i++) begin
            cycle("stream", 1, 3'($urandom), 3'($urandom), rand_pol(), 1, 0);
            chk("stream_count_le1", 64'(fifo_count_o <= 1), 64'd1);
        end
        chk("stream_drop0", 64'(drop_cnt_o), 64'd0);
        repeat (2) cycle("drain1", 0, 0, 0, 0, 1, 0);

        // Fill and stall
        for (int i = 0; i < DEPTH; i++)
            cycle("fill", 1, 3'($urandom), 3'($urandom), rand_pol(), 0, 0);
        chk("fill_full", 64'(full_o), 64'd1);
        chk("fill_ready", 64'(evt_ready_o), 64'd0);
        cycle("overflow", 1, 3'd1, 3'd1, 2'b10, 0, 0);
        chk("overflow_drop", 64'(drop_cnt_o), 64'd1);
        base_ts = mq[0][38:7];
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_ts_consecutive", 64'(pkt_data_o[38:7]), 64'(base_ts + 32'(i)));
            cycle("drain2", 0, 0, 0, 0, 1, 0);
        end

        // Invalid polarity
        cycle("pol00", 1, 3'd2, 3'd2, 2'b00, 0, 0);
        chk("pol00_empty", 64'(empty_o), 64'd1);
        cycle("pol11", 1, 3'd2, 3'd2, 2'b11, 0, 0);
        chk("pol11_empty", 64'(empty_o), 64'd1);
        chk("pol_drop", 64'(drop_cnt_o), 64'd3);

        // Timestamp wrap
        force dut.r_ts = 32'hFFFF_FFFE;
        #1;
        release dut.r_ts;
        m_ts = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++)
            cycle("wrap", 1, 3'($urandom), 3'($urandom), rand_pol(), 0, 0);
        chk("wrap_ts0", 64'(pkt_data_o[38:7]), 64'h0000_0000_FFFF_FFFE);
        cycle("wrap_d", 0, 0, 0, 0, 1, 0);
        chk("wrap_ts1", 64'(pkt_data_o[38:7]), 64'h0000_0000_FFFF_FFFF);
        cycle("wrap_d", 0, 0, 0, 0, 1, 0);
        chk("wrap_ts2", 64'(pkt_data_o[38:7]), 64'd0);
        cycle("wrap_d", 0, 0, 0, 0, 1, 0);

        // Clear then event
        cycle("clear", 0, 0, 0, 0, 0, 1);
        cycle("after_clear", 1, 3'd4, 3'd6, 2'b01, 0, 0);
        chk("clear_ts", 64'(pkt_data_o[38:7]), 64'd0);
        cycle("drain3", 0, 0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 200; i++)
            cycle("random", 1'($urandom), 3'($urandom), 3'($urandom),
                  2'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        repeat (DEPTH + 1) cycle("drain4", 0, 0, 0, 0, 1, 0);

        // Reset mid-operation with 7 entries queued
        for (int i = 0; i < 7; i++)
            cycle("queue7", 1, 3'($urandom), 3'($urandom), rand_pol(), 0, 0);
        chk("queue7_count", 64'(fifo_count_o), 64'd7);
        reset_i = 1'b0;
        #1;
        mq.delete(); m_ts = '0; m_drop = '0;
        chk("rst_async_valid", 64'(pkt_valid_o), 64'd0);
        chk("rst_async_empty", 64'(empty_o), 64'd1);
        chk("rst_async_count", 64'(fifo_count_o), 64'd0);
        chk("rst_async_drop",  64'(drop_cnt_o), 64'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        repeat (3) cycle("post_rst_idle", 0, 0, 0, 0, 0, 0);
        cycle("post_rst_evt", 1, 3'd7, 3'd0, 2'b10, 0, 0);
        chk("post_rst_ts", 64'(pkt_data_o[38:7]), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_packet_fifo.md
# event_packet_fifo

Downstream stage of the pixel-array arbiter. Each granted pixel event (row address, column address, 2-bit polarity pair) is stamped with a free-running 32-bit timestamp and packed into one WIDTH-bit (39-bit) event word. The word is buffered in a first-word-fall-through FIFO and drained over a valid/ready stream toward the readout/serializer interface.

## Interface
Parameters (widths come from `arbiter_pkg`):
- `FIFO_DEPTH`, 16: event word entries; must be a power of 2, at least 2.
- `DROP_W`, 16: width of the drop counter.

Ports:
- `clk_i`, in, 1: single clock.
- `reset_i`, in, 1: asynchronous, active-low reset.
- `ts_clear_i`, in, 1: synchronous clear of the timestamp counter.
- `evt_valid_i`, in, 1: arbiter presents a granted event.
- `evt_ready_o`, out, 1: block accepts the event.
- `row_add_i`, in, ROW_ADD: granted row index.
- `col_add_i`, in, COL_ADD: granted column index.
- `polarity_i`, in, POLARITY: pixel pair. 2'b10 means ON, 2'b01 means OFF, anything else is invalid.
- `pkt_valid_o`, out, 1: head word available.
- `pkt_ready_i`, in, 1: consumer takes the head word.
- `pkt_data_o`, out, WIDTH: event word {ts[31:0], row[2:0], col[2:0], pol}.
- `fifo_count_o`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `full_o`, out, 1: FIFO is full.
- `empty_o`, out, 1: FIFO is empty.
- `drop_cnt_o`, out, DROP_W: saturating count of discarded events.

## Operation
- **Timestamp counter**
  - SIZE-bit free-running counter that increments every cycle.
  - Wraps from 32'hFFFF_FFFF to 0.
  - `ts_clear_i` forces it to 0 on the next edge; clear wins over increment.
- **Accept:** `accept = evt_valid_i & evt_ready_o`.
  - `evt_ready_o = !full_o`. It is purely registered state and has no combinational path from `pkt_ready_i`.
- **Valid accepted event** (polarity 2'b10 or 2'b01):
  - Word = {ts_current, row_add_i, col_add_i, polarity_i[1]}. Bit 0 is 1 for ON, 0 for OFF.
  - ts_current is the counter value in the accept cycle, before that cycle's increment.
- **Invalid polarity** (2'b00 or 2'b11):
  - The handshake still completes and nothing is written.
  - `drop_cnt_o` increments.
- **Push and pop:**
  - Push happens on a valid accept.
  - Pop happens on `pkt_valid_o & pkt_ready_i`.
  - Simultaneous push and pop leaves the count unchanged and pointers both advance. This is legal at any non-full occupancy, including empty→1→0 across consecutive cycles.
- **`drop_cnt_o`:**
  - Also increments when `evt_valid_i` is high while full (arbiter protocol violation). That event is lost.
  - Saturates at all-ones.
- **Pointers:** read/write pointers are $clog2(FIFO_DEPTH)+1 bits with an MSB wrap bit.
  - full = MSBs differ and the rest are equal.
  - empty = pointers are equal.
- **Outputs:** `pkt_data_o` = mem[rd_ptr] (fall-through). Its value is don't-care while empty; the bench checks it only when valid.
- **Reset** (async assert, sync release), mid-operation included:
  - Pointers, count, timestamp and drop counter go to 0.
  - The contents of the FIFO are discarded.
  - Reset values: `evt_ready_o`=1, `pkt_valid_o`=0, `full_o`=0, `empty_o`=1, `fifo_count_o`=0, `drop_cnt_o`=0, `pkt_data_o`=don't-care.

## Timing
- Write latency: an event accepted on edge N appears at `pkt_valid_o`/`pkt_data_o` after edge N, i.e. one cycle from accept.
- No bypass: an empty FIFO never presents an event in the same cycle it is offered.
- Sustained throughput is 1 event/cycle in and out.
- `full_o`, `empty_o` and `fifo_count_o` are updated at the same edge as the pointers.
- `evt_ready_o` drops in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.

## Structure
- **Shared package `arbiter_pkg`** gains:
  - `FIFO_DEPTH`
  - `DROP_W`
  - `PTR_W = $clog2(FIFO_DEPTH)`
  - `POL_ON = 2'b10`, `POL_OFF = 2'b01`
  - a packed struct `event_t` {logic [SIZE-1:0] ts; logic [ROW_ADD-1:0] row; logic [COL_ADD-1:0] col; logic pol;}, whose width must equal WIDTH. A static assertion checks this.
- **Sub-module `sync_fifo_fwft`** (parameterised by WIDTH and DEPTH):
  - Holds storage, pointers and the full/empty/count logic.
  - The top level holds the timestamp counter, polarity check, packing and drop counter.

## Test plan
- **Single ON event:** reset, run 5 cycles, then offer row 3, col 5, pol 2'b10.
  - The word is {ts=5, 3'd3, 3'd5, 1'b1}.
  - `pkt_valid_o` rises the next cycle and `fifo_count_o`=1.
- **Fill and stall:** 16 back-to-back valid events with `pkt_ready_i`=0.
  - `full_o`=1 and `evt_ready_o`=0 after the 16th.
  - A 17th offered event bumps `drop_cnt_o` to 1.
  - After draining, all 16 words come out in order with consecutive timestamps.
- **Streaming:** continuous push and pop with `pkt_ready_i`=1 for 100 cycles.
  - `fifo_count_o` stays ≤1 and `drop_cnt_o`=0.
  - Output timestamps increase by 1 per word.
- **Invalid polarity:** offer pol 2'b00, then 2'b11.
  - Both handshakes complete with no push.
  - `drop_cnt_o`=2 and `empty_o` stays 1.
- **Timestamp wrap and clear:**
  - Force the counter near 32'hFFFF_FFFE and accept events across the wrap. Stamps are FFFF_FFFE, FFFF_FFFF, 0000_0000.
  - `ts_clear_i` followed by an event the next cycle gives stamp 0.
- **Reset mid-operation:** assert `reset_i` low with 7 entries queued.
  - `pkt_valid_o`=0, `empty_o`=1, `fifo_count_o`=0 and `drop_cnt_o`=0 immediately, without waiting for a clock edge.
  - After release, the first new event carries ts=0 plus the cycles elapsed since release.
